cheshire_regbus_demux_tmo: RTL

- Register-bus demultiplexer directly downstream of the AXI-to-Regbus bridge on the Regbus crossbar output.
- Decodes each 48-bit request against a start/end rule table and forwards it to exactly one of NumOut Regbus peripherals (bootrom, CSR, LLC cfg, UART, ...).
- Returns an error response on address miss and, optionally, on peripheral timeout, so a hung or absent slave cannot stall the core.
- One transaction in flight; all responses are registered.

---
 rtl/cheshire_regbus_demux_tmo.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/cheshire_regbus_demux_tmo.sv
// Regbus demux with one transaction in flight: start/end rule decode, error on miss,
// optional peripheral timeout enabled by CHESHIRE_REGBUS_DEMUX_TIMEOUT_EN.

module cheshire_regbus_demux_rule #(
    parameter int unsigned AddrWidth = 48
) (
    input  logic [AddrWidth-1:0] addr,
    input  logic [AddrWidth-1:0] start_addr,
    input  logic [AddrWidth-1:0] end_addr,
    output logic                 match
);
    // An empty or inverted window never matches.
    assign match = (start_addr < end_addr) && (addr >= start_addr) && (addr < end_addr);
endmodule

module cheshire_regbus_demux_tmo #(
    parameter int unsigned AddrWidth     = 48,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned NumOut        = 11,
    parameter int unsigned NumRules      = 11,
    parameter int unsigned TimeoutCycles = 1024,
    parameter logic [DataWidth-1:0] ErrData = 'hBADCAB1E,
    localparam int unsigned StrbWidth    = DataWidth / 8,
    localparam int unsigned IdxWidth     = (NumOut > 1) ? $clog2(NumOut) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumRules*AddrWidth-1:0] rule_start_i,
    input  logic [NumRules*AddrWidth-1:0] rule_end_i,
    input  logic [NumRules*IdxWidth-1:0]  rule_idx_i,
    input  logic                          in_valid_i,
    input  logic                          in_write_i,
    input  logic [AddrWidth-1:0]          in_addr_i,
    input  logic [DataWidth-1:0]          in_wdata_i,
    input  logic [StrbWidth-1:0]          in_wstrb_i,
    output logic                          in_ready_o,
    output logic [DataWidth-1:0]          in_rdata_o,
    output logic                          in_error_o,
    output logic [NumOut-1:0]             out_valid_o,
    output logic                          out_write_o,
    output logic [AddrWidth-1:0]          out_addr_o,
    output logic [DataWidth-1:0]          out_wdata_o,
    output logic [StrbWidth-1:0]          out_wstrb_o,
    input  logic [NumOut-1:0]             out_ready_i,
    input  logic [NumOut*DataWidth-1:0]   out_rdata_i,
    input  logic [NumOut-1:0]             out_error_i,
    output logic                          timeout_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StFwd  = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    if (TimeoutCycles < 2) begin : g_tmo_check
        $error("TimeoutCycles must be at least 2");
    end

    logic [1:0]           state;
    logic [IdxWidth-1:0]  sel;
    logic [DataWidth-1:0] rdata_q;
    logic                 error_q;

    logic [NumRules-1:0]  rule_hit;
    logic                 dec_hit;
    logic [IdxWidth-1:0]  dec_idx;

    logic                 sel_ready;
    logic                 sel_error;
    logic [DataWidth-1:0] sel_rdata;
    logic                 tmo_hit;

    for (genvar r = 0; r < NumRules; r++) begin : g_rule
        cheshire_regbus_demux_rule #(
            .AddrWidth (AddrWidth)
        ) i_rule (
            .addr       (in_addr_i),
            .start_addr (rule_start_i[r*AddrWidth +: AddrWidth]),
            .end_addr   (rule_end_i[r*AddrWidth +: AddrWidth]),
            .match      (rule_hit[r])
        );
    end

    // Walk downwards so the lowest matching rule is the one left standing.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int r = NumRules - 1; r >= 0; r--) begin
            if (rule_hit[r]) begin
                dec_hit = 1'b1;
                dec_idx = rule_idx_i[r*IdxWidth +: IdxWidth];
            end
        end
        if (32'(dec_idx) >= NumOut) dec_hit = 1'b0;
    end

    always_comb begin
        sel_ready = out_ready_i[sel];
        sel_error = out_error_i[sel];
        sel_rdata = out_rdata_i[sel*DataWidth +: DataWidth];
    end

`ifdef CHESHIRE_REGBUS_DEMUX_TIMEOUT_EN
    localparam int unsigned CntWidth = $clog2(TimeoutCycles);

    logic [CntWidth-1:0] cnt;
    logic                tmo_q;

    // A ready in the limit cycle takes priority over the timeout.
    assign tmo_hit = (state == StFwd) && !sel_ready && (cnt == CntWidth'(TimeoutCycles - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt       <= '0;
            tmo_q     <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= (state == StResp) && tmo_q;
            if (state == StIdle) begin
                cnt   <= '0;
                tmo_q <= 1'b0;
            end else if (state == StFwd) begin
                if (tmo_hit)         tmo_q <= 1'b1;
                else if (!sel_ready) cnt   <= cnt + CntWidth'(1);
            end
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= StIdle;
            sel         <= '0;
            rdata_q     <= '0;
            error_q     <= 1'b0;
            in_ready_o  <= 1'b0;
            in_rdata_o  <= '0;
            in_error_o  <= 1'b0;
            out_valid_o <= '0;
            out_write_o <= 1'b0;
            out_addr_o  <= '0;
            out_wdata_o <= '0;
            out_wstrb_o <= '0;
        end else begin
            in_ready_o <= 1'b0;
            case (state)
                StIdle: begin
                    // Skip the cycle where the previous response is still on the bus.
                    if (in_valid_i && !in_ready_o) begin
                        out_write_o <= in_write_i;
                        out_addr_o  <= in_addr_i;
                        out_wdata_o <= in_wdata_i;
                        out_wstrb_o <= in_wstrb_i;
                        sel         <= dec_idx;
                        if (dec_hit) begin
                            out_valid_o <= NumOut'(1) << dec_idx;
                            state       <= StFwd;
                        end else begin
                            rdata_q <= ErrData;
                            error_q <= 1'b1;
                            state   <= StResp;
                        end
                    end
                end
                StFwd: begin
                    if (sel_ready) begin
                        out_valid_o <= '0;
                        rdata_q     <= sel_rdata;
                        error_q     <= sel_error;
                        state       <= StResp;
                    end else if (tmo_hit) begin
                        out_valid_o <= '0;
                        rdata_q     <= ErrData;
                        error_q     <= 1'b1;
                        state       <= StResp;
                    end
                end
                StResp: begin
                    in_ready_o <= 1'b1;
                    in_error_o <= error_q;
                    in_rdata_o <= (out_write_o && !error_q) ? '0 : rdata_q;
                    state      <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
